simd_alu_sat_stage: RTL

Downstream result stage of the 256-bit SIMD ALU. Consumes the ALU result word with its per-byte overflow/underflow flags and per-beat lane mode. Optionally clamps each flagged lane to its saturation value, then buffers results in a 2-entry valid/ready queue toward the writeback consumer. Keeps sticky per-byte flag status and a saturation event counter for software.

---
 rtl/simd_alu_sat_stage.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/simd_alu_sat_stage.sv
// Result stage of the SIMD ALU. It clamps flagged lanes to their saturation value,
// buffers beats in a 2-entry valid/ready queue, and keeps sticky flag status and a saturation count.
module simd_alu_sat_stage #(
  parameter int SIMD_DATA_WIDTH = 256,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SIMD_DATA_WIDTH-1:0]   in_data,
  input  logic [SIMD_DATA_WIDTH/8-1:0] in_ovf,
  input  logic [SIMD_DATA_WIDTH/8-1:0] in_udf,
  input  logic [1:0]                   in_mode,
  input  logic                         in_signed,
  input  logic                         in_sat_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SIMD_DATA_WIDTH-1:0]   out_data,
  output logic [SIMD_DATA_WIDTH/8-1:0] out_ovf,
  output logic [SIMD_DATA_WIDTH/8-1:0] out_udf,
  output logic [SIMD_DATA_WIDTH/8-1:0] sticky_ovf,
  output logic [SIMD_DATA_WIDTH/8-1:0] sticky_udf,
  output logic [CNT_WIDTH-1:0]         sat_count,
  input  logic                         flag_clr
);

  localparam int NB = SIMD_DATA_WIDTH / 8;

  logic [NB-1:0]              lane_ovf, lane_udf, lane_top;
  logic [SIMD_DATA_WIDTH-1:0] sat_data;
  logic                       clamp_any;
  logic                       accept, pop;
  logic [1:0]                 occ_after_pop;
  logic [CNT_WIDTH-1:0]       cnt_base;

  logic [SIMD_DATA_WIDTH-1:0] ent0_data_q, ent0_data_d, ent1_data_q, ent1_data_d;
  logic [NB-1:0]              ent0_ovf_q, ent0_ovf_d, ent1_ovf_q, ent1_ovf_d;
  logic [NB-1:0]              ent0_udf_q, ent0_udf_d, ent1_udf_q, ent1_udf_d;
  logic [1:0]                 occ_q, occ_d;
  logic [NB-1:0]              sticky_ovf_q, sticky_ovf_d, sticky_udf_q, sticky_udf_d;
  logic [CNT_WIDTH-1:0]       sat_count_q, sat_count_d;

  // Each byte sees the OR of its lane's flags; lane_top marks the lane's most significant byte.
  always_comb begin
    lane_ovf = '0;
    lane_udf = '0;
    lane_top = '0;
    for (int b = 0; b < NB; b++) begin
      case (in_mode)
        2'd0: begin
          lane_ovf[b] = in_ovf[b];
          lane_udf[b] = in_udf[b];
          lane_top[b] = 1'b1;
        end
        2'd1: begin
          lane_ovf[b] = |in_ovf[(b/2)*2 +: 2];
          lane_udf[b] = |in_udf[(b/2)*2 +: 2];
          lane_top[b] = (b % 2) == 1;
        end
        2'd2: begin
          lane_ovf[b] = |in_ovf[(b/4)*4 +: 4];
          lane_udf[b] = |in_udf[(b/4)*4 +: 4];
          lane_top[b] = (b % 4) == 3;
        end
        default: begin
          lane_ovf[b] = |in_ovf[(b/8)*8 +: 8];
          lane_udf[b] = |in_udf[(b/8)*8 +: 8];
          lane_top[b] = (b % 8) == 7;
        end
      endcase
    end
  end

  always_comb begin
    sat_data = in_data;
    if (in_sat_en) begin
      for (int b = 0; b < NB; b++) begin
        if (lane_ovf[b]) begin
          sat_data[b*8 +: 8] = (in_signed && lane_top[b]) ? 8'h7F : 8'hFF;
        end else if (lane_udf[b]) begin
          sat_data[b*8 +: 8] = (in_signed && lane_top[b]) ? 8'h80 : 8'h00;
        end
      end
    end
  end

  // Any flagged byte implies its whole lane is clamped.
  assign clamp_any = in_sat_en && ((|in_ovf) || (|in_udf));

  assign in_ready  = rst_n && (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = ent0_data_q;
  assign out_ovf   = ent0_ovf_q;
  assign out_udf   = ent0_udf_q;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Entry 0 is always the head; a pop shifts entry 1 down before the new beat lands.
  always_comb begin
    ent0_data_d = ent0_data_q;
    ent0_ovf_d  = ent0_ovf_q;
    ent0_udf_d  = ent0_udf_q;
    ent1_data_d = ent1_data_q;
    ent1_ovf_d  = ent1_ovf_q;
    ent1_udf_d  = ent1_udf_q;
    if (pop) begin
      ent0_data_d = ent1_data_q;
      ent0_ovf_d  = ent1_ovf_q;
      ent0_udf_d  = ent1_udf_q;
    end
    occ_after_pop = occ_q - {1'b0, pop};
    if (accept) begin
      if (occ_after_pop == 2'd0) begin
        ent0_data_d = sat_data;
        ent0_ovf_d  = in_ovf;
        ent0_udf_d  = in_udf;
      end else begin
        ent1_data_d = sat_data;
        ent1_ovf_d  = in_ovf;
        ent1_udf_d  = in_udf;
      end
    end
    occ_d = occ_after_pop + {1'b0, accept};
  end

  // A clear in the same cycle as an accept leaves only that beat's contribution.
  always_comb begin
    sticky_ovf_d = (flag_clr ? '0 : sticky_ovf_q) | ({NB{accept}} & in_ovf);
    sticky_udf_d = (flag_clr ? '0 : sticky_udf_q) | ({NB{accept}} & in_udf);
    cnt_base     = flag_clr ? '0 : sat_count_q;
    sat_count_d  = cnt_base;
    if (accept && clamp_any && (cnt_base != {CNT_WIDTH{1'b1}})) begin
      sat_count_d = cnt_base + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_data_q  <= '0;
      ent0_ovf_q   <= '0;
      ent0_udf_q   <= '0;
      ent1_data_q  <= '0;
      ent1_ovf_q   <= '0;
      ent1_udf_q   <= '0;
      occ_q        <= 2'd0;
      sticky_ovf_q <= '0;
      sticky_udf_q <= '0;
      sat_count_q  <= '0;
    end else begin
      ent0_data_q  <= ent0_data_d;
      ent0_ovf_q   <= ent0_ovf_d;
      ent0_udf_q   <= ent0_udf_d;
      ent1_data_q  <= ent1_data_d;
      ent1_ovf_q   <= ent1_ovf_d;
      ent1_udf_q   <= ent1_udf_d;
      occ_q        <= occ_d;
      sticky_ovf_q <= sticky_ovf_d;
      sticky_udf_q <= sticky_udf_d;
      sat_count_q  <= sat_count_d;
    end
  end

  assign sticky_ovf = sticky_ovf_q;
  assign sticky_udf = sticky_udf_q;
  assign sat_count  = sat_count_q;

endmodule
